// File: rtl/dm_pkg.sv
// dm_pkg: shared definitions for the data-memory burst master.
//   Default address/data/length widths, the largest burst size, and the
//   controller state encoding (kept as explicit 2-bit values so the state
//   vector matches the original hard-coded encodings bit for bit).
package dm_pkg;

  localparam int unsigned ADDR_W_DEF = 8;
  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned LEN_W_DEF  = 4;
  localparam int unsigned MAX_BURST  = 2 ** LEN_W_DEF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_WRITE = 2'd3
  } dm_state_e;

endpackage

// File: rtl/dm_burst_counter.sv
// dm_burst_counter: address sequencer / remaining-beat counter for a burst.
//   clk, rst    : clock, synchronous active-high reset
//   load        : capture addr_in / len_in as the burst start
//   step        : advance one beat (addr + 1 wrapping, cnt - 1)
//   addr_in     : burst start address
//   len_in      : burst length minus one
//   addr        : current beat address
//   last        : current beat is the final one (cnt == 0)
module dm_burst_counter #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned LEN_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [LEN_W-1:0]  len_in,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  logic [LEN_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      addr <= '0;
      cnt  <= '0;
    end else if (load) begin
      addr <= addr_in;
      cnt  <= len_in;
    end else if (step) begin
      // Address wraps naturally modulo 2^ADDR_W.
      addr <= addr + 1'b1;
      cnt  <= cnt - 1'b1;
    end
  end

  assign last = (cnt == '0);

endmodule

// File: rtl/dm_burst_master.sv
// dm_burst_master: burst load/store initiator for the 256-byte data memory.
//   clk, rst            : clock, synchronous active-high reset
//   req_valid/req_ready : request handshake; req_we selects store (1) or load (0),
//                         req_addr is the start address, req_len the byte count - 1
//   wr_data/wr_valid/wr_ready : store byte stream (beat when wr_valid in WRITE)
//   rd_data/rd_valid    : load byte stream, no backpressure
//   done                : one-cycle pulse when a burst completes
//   busy                : burst in progress
//   en_DM_rd, en_DM_wr, mem_addr, mem_din, mem_dout : data memory port
//                         (memory read data is registered, one cycle latency)
module dm_burst_master
  import dm_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned LEN_W  = LEN_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [LEN_W-1:0]  req_len,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              done,
  output logic              busy,
  output logic              en_DM_rd,
  output logic              en_DM_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout
);

  dm_state_e         state, nstate;
  logic              rd_pend;
  logic              load, step, last;
  logic              rd_en, wr_en, wr_rdy, done_c;
  logic [ADDR_W-1:0] addr_q;

  dm_burst_counter #(
    .ADDR_W (ADDR_W),
    .LEN_W  (LEN_W)
  ) u_cnt (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .step    (step),
    .addr_in (req_addr),
    .len_in  (req_len),
    .addr    (addr_q),
    .last    (last)
  );

  always_comb begin
    nstate = state;
    load   = 1'b0;
    step   = 1'b0;
    rd_en  = 1'b0;
    wr_en  = 1'b0;
    wr_rdy = 1'b0;
    done_c = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req_valid) begin
          load   = 1'b1;
          nstate = req_we ? ST_WRITE : ST_READ;
        end
      end
      ST_READ: begin
        rd_en = 1'b1;
        step  = 1'b1;
        if (last) nstate = ST_DRAIN;
      end
      // Carries the final registered read byte out of the memory.
      ST_DRAIN: begin
        done_c = 1'b1;
        nstate = ST_IDLE;
      end
      ST_WRITE: begin
        wr_rdy = 1'b1;
        if (wr_valid) begin
          wr_en = 1'b1;
          step  = 1'b1;
          if (last) begin
            done_c = 1'b1;
            nstate = ST_IDLE;
          end
        end
      end
      default: nstate = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      rd_pend <= 1'b0;
    end else begin
      state   <= nstate;
      rd_pend <= rd_en;
    end
  end

  // Every output is forced low while rst is high, so a burst aborted by reset
  // issues no further memory access and no rd_valid/done for in-flight reads.
  assign req_ready = (state == ST_IDLE) && !rst;
  assign busy      = (state != ST_IDLE) && !rst;
  assign wr_ready  = wr_rdy && !rst;
  assign en_DM_rd  = rd_en && !rst;
  assign en_DM_wr  = wr_en && !rst;
  assign done      = done_c && !rst;
  assign rd_valid  = rd_pend && !rst;
  assign rd_data   = rst ? '0 : mem_dout;
  assign mem_addr  = rst ? '0 : addr_q;
  assign mem_din   = rst ? '0 : wr_data;

endmodule

// File: tb/tb_dm_burst_master.sv
// tb_dm_burst_master: directed self-checking bench for dm_burst_master with a
// behavioural 256-byte registered-read memory attached to the memory port.
module tb_dm_burst_master;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid, req_ready, req_we;
  logic [7:0] req_addr;
  logic [3:0] req_len;
  logic [7:0] wr_data;
  logic       wr_valid, wr_ready;
  logic [7:0] rd_data;
  logic       rd_valid, done, busy;
  logic       en_DM_rd, en_DM_wr;
  logic [7:0] mem_addr, mem_din, mem_dout;

  logic [7:0] mem     [256];
  logic [7:0] exp_mem [256];
  logic [7:0] wdata   [16];
  logic       mem_init;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  dm_burst_master #(
    .ADDR_W (8),
    .DATA_W (8),
    .LEN_W  (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_len   (req_len),
    .wr_data   (wr_data),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .done      (done),
    .busy      (busy),
    .en_DM_rd  (en_DM_rd),
    .en_DM_wr  (en_DM_wr),
    .mem_addr  (mem_addr),
    .mem_din   (mem_din),
    .mem_dout  (mem_dout)
  );

  // Data memory: synchronous write, registered read.
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'(i) ^ 8'h5A;
    end else begin
      if (en_DM_wr) mem[mem_addr] <= mem_din;
      if (en_DM_rd) mem_dout <= mem[mem_addr];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic run_store(input logic [7:0] a, input logic [3:0] l,
                           input int stall_at, input int stall_n);
    logic [7:0] ea;
    req_valid = 1'b1; req_we = 1'b1; req_addr = a; req_len = l; wr_valid = 1'b0;
    settle();
    check("st_req_ready", 32'(req_ready), 1);
    tick();
    req_valid = 1'b0;
    for (int b = 0; b <= int'(l); b++) begin
      ea = a + 8'(b);
      if (b == stall_at) begin
        for (int s = 0; s < stall_n; s++) begin
          wr_valid = 1'b0;
          settle();
          check("st_stall_wr",    32'(en_DM_wr), 0);
          check("st_stall_addr",  32'(mem_addr), 32'(ea));
          check("st_stall_done",  32'(done), 0);
          check("st_stall_ready", 32'(wr_ready), 1);
          tick();
        end
      end
      wr_valid = 1'b1;
      wr_data  = wdata[b];
      settle();
      check("st_busy",  32'(busy), 1);
      check("st_wr_en", 32'(en_DM_wr), 1);
      check("st_rd_en", 32'(en_DM_rd), 0);
      check("st_addr",  32'(mem_addr), 32'(ea));
      check("st_din",   32'(mem_din), 32'(wdata[b]));
      check("st_done",  32'(done), 32'(b == int'(l)));
      exp_mem[ea] = wdata[b];
      tick();
    end
    wr_valid = 1'b0;
    settle();
    check("st_end_busy", 32'(busy), 0);
    check("st_end_done", 32'(done), 0);
    for (int b = 0; b <= int'(l); b++) begin
      ea = a + 8'(b);
      check("st_mem", 32'(mem[ea]), 32'(wdata[b]));
    end
  endtask

  // hold=1 keeps a store request to 0x40 pending for the whole load.
  task automatic run_load(input logic [7:0] a, input logic [3:0] l, input bit hold);
    logic [7:0] ea, eb;
    req_valid = 1'b1; req_we = 1'b0; req_addr = a; req_len = l;
    settle();
    check("ld_req_ready", 32'(req_ready), 1);
    tick();
    if (hold) begin
      req_we = 1'b1; req_addr = 8'h40; req_len = 4'd0;
    end else begin
      req_valid = 1'b0;
    end
    for (int k = 0; k <= int'(l); k++) begin
      ea = a + 8'(k);
      eb = a + 8'(k - 1);
      settle();
      check("ld_rd_en",   32'(en_DM_rd), 1);
      check("ld_wr_en",   32'(en_DM_wr), 0);
      check("ld_addr",    32'(mem_addr), 32'(ea));
      check("ld_done",    32'(done), 0);
      check("ld_busy",    32'(busy), 1);
      check("ld_ready",   32'(req_ready), 0);
      check("ld_rdvalid", 32'(rd_valid), 32'(k != 0));
      if (k != 0) check("ld_rdata", 32'(rd_data), 32'(exp_mem[eb]));
      tick();
    end
    ea = a + 8'(l);
    settle();
    check("drain_rdvalid", 32'(rd_valid), 1);
    check("drain_rdata",   32'(rd_data), 32'(exp_mem[ea]));
    check("drain_done",    32'(done), 1);
    check("drain_rd_en",   32'(en_DM_rd), 0);
    check("drain_busy",    32'(busy), 1);
    check("drain_ready",   32'(req_ready), 0);
    tick();
    settle();
    check("ld_end_busy",    32'(busy), 0);
    check("ld_end_rdvalid", 32'(rd_valid), 0);
    check("ld_end_done",    32'(done), 0);
    check("ld_end_ready",   32'(req_ready), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; mem_init = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_len = '0;
    wr_valid = 1'b0; wr_data = '0;
    for (int i = 0; i < 256; i++) exp_mem[i] = 8'(i) ^ 8'h5A;
    tick();
    tick();
    // Outputs must stay low under reset even with a request and write data present.
    req_valid = 1'b1; wr_valid = 1'b1;
    settle();
    check("rst_req_ready", 32'(req_ready), 0);
    check("rst_busy",      32'(busy), 0);
    check("rst_rd_en",     32'(en_DM_rd), 0);
    check("rst_wr_en",     32'(en_DM_wr), 0);
    check("rst_rdvalid",   32'(rd_valid), 0);
    check("rst_done",      32'(done), 0);
    check("rst_wr_ready",  32'(wr_ready), 0);
    tick();
    mem_init = 1'b0; rst = 1'b0; req_valid = 1'b0; wr_valid = 1'b0;
    settle();
    check("post_rst_ready", 32'(req_ready), 1);
    check("post_rst_busy",  32'(busy), 0);

    // Single store then load to 0x10.
    wdata[0] = 8'hA5;
    run_store(8'h10, 4'd0, -1, 0);
    run_load(8'h10, 4'd0, 1'b0);

    // Wrapping 4-byte store then load from 0xFE.
    wdata[0] = 8'h01; wdata[1] = 8'h02; wdata[2] = 8'h03; wdata[3] = 8'h04;
    run_store(8'hFE, 4'd3, -1, 0);
    run_load(8'hFE, 4'd3, 1'b0);

    // 3-byte store with a 2-cycle stall after the first beat.
    wdata[0] = 8'h31; wdata[1] = 8'h32; wdata[2] = 8'h33;
    run_store(8'h20, 4'd2, 1, 2);

    // Maximum 16-byte load from 0x00 (0x00/0x01 hold 0x03/0x04 from the wrap store).
    run_load(8'h00, 4'd15, 1'b0);

    // Reset during the third READ cycle of a 16-byte load.
    req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h00; req_len = 4'd15;
    settle();
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    settle();
    check("abort_rst_rd_en",   32'(en_DM_rd), 0);
    check("abort_rst_rdvalid", 32'(rd_valid), 0);
    check("abort_rst_done",    32'(done), 0);
    check("abort_rst_busy",    32'(busy), 0);
    tick();
    rst = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h10; req_len = 4'd0;
    settle();
    check("abort_busy",    32'(busy), 0);
    check("abort_rdvalid", 32'(rd_valid), 0);
    check("abort_done",    32'(done), 0);
    check("abort_ready",   32'(req_ready), 1);
    tick();
    req_valid = 1'b0;
    settle();
    check("reacc_rd_en", 32'(en_DM_rd), 1);
    check("reacc_addr",  32'(mem_addr), 32'h10);
    tick();
    settle();
    check("reacc_rdvalid", 32'(rd_valid), 1);
    check("reacc_rdata",   32'(rd_data), 32'hA5);
    check("reacc_done",    32'(done), 1);
    tick();
    settle();
    check("reacc_end_busy", 32'(busy), 0);

    // Store request to 0x40 held throughout an 8-byte load from 0xFE.
    run_load(8'hFE, 4'd7, 1'b1);
    tick();
    req_valid = 1'b0;
    wr_valid = 1'b1; wr_data = 8'h77;
    settle();
    check("held_busy",  32'(busy), 1);
    check("held_wr_en", 32'(en_DM_wr), 1);
    check("held_addr",  32'(mem_addr), 32'h40);
    check("held_din",   32'(mem_din), 32'h77);
    check("held_done",  32'(done), 1);
    tick();
    wr_valid = 1'b0;
    settle();
    check("held_end_busy", 32'(busy), 0);
    check("held_mem",      32'(mem[8'h40]), 32'h77);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
